// File: rtl/volume_attenuator.sv
// Arithmetic right-shift attenuator on a valid/ready sample stream.
// Attenuation ramps one 6 dB step per RAMP_SAMPLES accepted samples toward atten_target.
module volume_attenuator #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned SHIFT_W      = 4,
   parameter int unsigned RAMP_SAMPLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SHIFT_W-1:0] atten_target,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SHIFT_W-1:0] atten_cur,
   output logic               ramping
);

   localparam int unsigned       CNT_W    = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_SAMPLES - 1);

   typedef enum logic {IDLE, STEP} state_t;

   state_t             state;
   logic               accept;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic [SHIFT_W-1:0] atten_q, atten_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign atten_cur = atten_q;
   assign ramping   = (atten_q != atten_target);

   // The ramp state is fully determined by the live comparison, so a target that
   // lands on atten_cur mid-count drops back to IDLE in the same cycle.
   assign state = (atten_q == atten_target) ? IDLE : STEP;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = $signed(in_data) >>> atten_q;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      atten_d = atten_q;
      cnt_d   = cnt_q;
      case (state)
         IDLE: cnt_d = '0;
         STEP: begin
            if (accept) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  atten_d = (atten_target > atten_q) ? atten_q + 1'b1 : atten_q - 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         atten_q     <= '1;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         atten_q     <= atten_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_volume_attenuator.sv
// Randomized bench for volume_attenuator against a sample-level behavioural model.
module tb_volume_attenuator;

   localparam int R = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  atten_target = 4'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic [3:0]  atten_cur;
   logic        ramping;

   int errors = 0;
   int checks = 0;

   bit          m_ov;
   logic [15:0] m_data;
   int          m_att, m_cnt, m_xfers, d_xfers;

   volume_attenuator #(.WIDTH(16), .SHIFT_W(4), .RAMP_SAMPLES(R)) dut (
      .clk(clk), .rst_n(rst_n), .atten_target(atten_target),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .atten_cur(atten_cur), .ramping(ramping)
   );

   always #5 clk = ~clk;

   // floor(x / 2^a) on the signed sample value
   function automatic logic [15:0] ref_shift(input logic [15:0] x, input int a);
      longint v, d, q;
      v = longint'($signed(x));
      d = longint'(1) << a;
      q = v / d;
      if ((v < 0) && (q * d != v)) q = q - 1;
      return q[15:0];
   endfunction

   task automatic model_reset();
      m_ov = 1'b0; m_data = 16'h0000; m_att = 15; m_cnt = 0;
   endtask

   // One clock: predict from the inputs presented, advance, update the model.
   task automatic cycle();
      bit acc, xfer;
      int tgt;
      logic [15:0] din;
      acc  = in_valid && (!m_ov || out_ready);
      xfer = m_ov && out_ready;
      tgt  = int'(atten_target);
      din  = in_data;
      if (out_valid && out_ready) d_xfers++;
      @(posedge clk); #1;
      if (acc) begin
         m_data = ref_shift(din, m_att);
         m_ov = 1'b1;
      end else if (xfer) begin
         m_ov = 1'b0;
      end
      if (xfer) m_xfers++;
      if (m_att == tgt) m_cnt = 0;
      else if (acc) begin
         m_cnt++;
         if (m_cnt == R) begin
            m_cnt = 0;
            m_att = m_att + ((tgt > m_att) ? 1 : -1);
         end
      end
   endtask

   task automatic test_reset();
      model_reset();
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
      checks++; if (atten_cur !== 4'd15) begin errors++; $display("FAIL reset_atten: got %0d want 15", atten_cur); end
      checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL reset_ramping: got %b want 1", ramping); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_ramp_in();
      atten_target = 4'd0; in_data = 16'h4000; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      for (int n = 1; n <= 61; n++) begin
         cycle();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid n=%0d: got %b want 1", n, out_valid); end
         checks++; if (out_data !== m_data) begin errors++; $display("FAIL ramp_data n=%0d: got %h want %h", n, out_data, m_data); end
         checks++; if (atten_cur !== m_att[3:0]) begin errors++; $display("FAIL ramp_atten n=%0d: got %0d want %0d", n, atten_cur, m_att); end
         if (n <= 4) begin
            checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL ramp_first4 n=%0d: got %h want 0000", n, out_data); end
         end else if (n <= 8) begin
            checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL ramp_next4 n=%0d: got %h want 0001", n, out_data); end
         end
         if (n == 59) begin
            checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL ramp_still n=59: got %b want 1", ramping); end
         end
         if (n == 60) begin
            checks++; if (atten_cur !== 4'd0) begin errors++; $display("FAIL ramp_done_atten: got %0d want 0", atten_cur); end
            checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL ramp_done_ramping: got %b want 0", ramping); end
         end
         if (n == 61) begin
            checks++; if (out_data !== 16'h4000) begin errors++; $display("FAIL ramp_unity: got %h want 4000", out_data); end
         end
      end
   endtask

   task automatic test_sign_ext();
      int guard;
      atten_target = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
      guard = 0;
      while (m_att != 3 && guard < 200) begin
         in_data = 16'($urandom);
         cycle();
         guard++;
         checks++; if (out_data !== m_data) begin errors++; $display("FAIL sign_ramp_data: got %h want %h", out_data, m_data); end
      end
      checks++; if (atten_cur !== 4'd3) begin errors++; $display("FAIL sign_atten: got %0d want 3", atten_cur); end
      in_data = 16'h8000; cycle();
      checks++; if (out_data !== 16'hF000) begin errors++; $display("FAIL sign_8000: got %h want F000", out_data); end
      in_data = 16'hFFFF; cycle();
      checks++; if (out_data !== 16'hFFFF) begin errors++; $display("FAIL sign_FFFF: got %h want FFFF", out_data); end
      for (int i = 0; i < 20; i++) begin
         in_data = 16'($urandom); cycle();
         checks++; if (out_data !== m_data) begin errors++; $display("FAIL sign_rand: got %h want %h", out_data, m_data); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] held;
      in_valid = 1'b0; out_ready = 1'b1; cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'($urandom);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_pre: got %b want 1", in_ready); end
      cycle();
      held = m_data;
      for (int i = 0; i < 5; i++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c=%0d: got %b want 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d: got %b want 1", i, out_valid); end
         checks++; if (out_data !== held) begin errors++; $display("FAIL bp_stable c=%0d: got %h want %h", i, out_data, held); end
         in_data = 16'($urandom);
         if (i < 4) cycle();
      end
   endtask

   task automatic test_random_stream();
      int guard;
      m_xfers = 0; d_xfers = 0; guard = 0;
      while (m_xfers < 100 && guard < 3000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_data   = 16'($urandom);
         if ($urandom_range(0, 39) == 0) atten_target = 4'($urandom_range(0, 15));
         #1;
         checks++; if (in_ready !== (!m_ov || out_ready)) begin errors++; $display("FAIL rs_in_ready: got %b want %b", in_ready, (!m_ov || out_ready)); end
         cycle();
         guard++;
         checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rs_valid: got %b want %b", out_valid, m_ov); end
         checks++; if (out_data !== m_data) begin errors++; $display("FAIL rs_data: got %h want %h", out_data, m_data); end
         checks++; if (atten_cur !== m_att[3:0]) begin errors++; $display("FAIL rs_atten: got %0d want %0d", atten_cur, m_att); end
         checks++; if (ramping !== (m_att != int'(atten_target))) begin errors++; $display("FAIL rs_ramping: got %b want %b", ramping, (m_att != int'(atten_target))); end
      end
      checks++; if (m_xfers < 100) begin errors++; $display("FAIL rs_timeout: got %0d want 100 transfers", m_xfers); end
      checks++; if (d_xfers != m_xfers) begin errors++; $display("FAIL rs_xfer_count: got %0d want %0d", d_xfers, m_xfers); end
   endtask

   task automatic test_reversal();
      int guard;
      #2 rst_n = 1'b0; model_reset();
      atten_target = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      guard = 0;
      while (!(m_att == 8 && m_cnt == 2) && guard < 200) begin
         in_data = 16'($urandom); cycle(); guard++;
      end
      checks++; if (atten_cur !== 4'd8) begin errors++; $display("FAIL rev_start: got %0d want 8", atten_cur); end
      atten_target = 4'd12;
      for (int k = 1; k <= 14; k++) begin
         in_data = 16'($urandom); cycle();
         checks++; if (atten_cur !== m_att[3:0]) begin errors++; $display("FAIL rev_model k=%0d: got %0d want %0d", k, atten_cur, m_att); end
         if (k == 2) begin
            checks++; if (atten_cur !== 4'd9) begin errors++; $display("FAIL rev_first_step: got %0d want 9", atten_cur); end
         end
         if (k == 6 || k == 10) begin
            checks++; if (atten_cur !== 4'(9 + (k - 2) / 4)) begin errors++; $display("FAIL rev_step k=%0d: got %0d want %0d", k, atten_cur, 9 + (k - 2) / 4); end
         end
         if (k == 14) begin
            checks++; if (atten_cur !== 4'd12) begin errors++; $display("FAIL rev_end_atten: got %0d want 12", atten_cur); end
            checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL rev_end_ramping: got %b want 0", ramping); end
         end
      end
   endtask

   task automatic test_stall();
      atten_target = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
      repeat (2) begin in_data = 16'($urandom); cycle(); end
      in_valid = 1'b0;
      repeat (1000) cycle();
      checks++; if (atten_cur !== 4'd12) begin errors++; $display("FAIL stall_atten: got %0d want 12", atten_cur); end
      checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL stall_ramping: got %b want 1", ramping); end
      in_valid = 1'b1; in_data = 16'($urandom); cycle();
      checks++; if (atten_cur !== 4'd12) begin errors++; $display("FAIL stall_resume1: got %0d want 12", atten_cur); end
      in_data = 16'($urandom); cycle();
      checks++; if (atten_cur !== 4'd11) begin errors++; $display("FAIL stall_resume2: got %0d want 11", atten_cur); end
      checks++; if (atten_cur !== m_att[3:0]) begin errors++; $display("FAIL stall_model: got %0d want %0d", atten_cur, m_att); end
   endtask

   task automatic test_async_reset();
      int guard;
      atten_target = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
      guard = 0;
      while (m_att != 5 && guard < 200) begin
         in_data = 16'($urandom | 32'h0000_4000); cycle(); guard++;
      end
      checks++; if (atten_cur !== 4'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre: got atten=%0d valid=%b want 5/1", atten_cur, out_valid); end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL ar_data: got %h want 0000", out_data); end
      checks++; if (atten_cur !== 4'd15) begin errors++; $display("FAIL ar_atten: got %0d want 15", atten_cur); end
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      cycle();
      checks++; if (out_valid !== 1'b0 || atten_cur !== 4'd15) begin errors++; $display("FAIL ar_after: got valid=%b atten=%0d want 0/15", out_valid, atten_cur); end
   endtask

   initial begin
      test_reset();
      test_ramp_in();
      test_sign_ext();
      test_backpressure();
      test_random_stream();
      test_reversal();
      test_stall();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/volume_attenuator.md
# volume_attenuator

Sequential audio attenuation stage, the counterpart of the left-shift volume boost in the playback path. It accepts signed PCM samples on a valid/ready stream and applies an arithmetic right-shift attenuation. The attenuation ramps one step at a time toward a programmable target, which avoids zipper noise and pops. It sits between the sample source and the DAC serializer and holds one sample in a registered output stage.

## Interface
- `WIDTH`, default 16: sample width, two's complement.
- `SHIFT_W`, default 4: attenuation code width; max attenuation `MAX_ATT = 2^SHIFT_W - 1`.
- `RAMP_SAMPLES`, default 64: accepted samples per attenuation step; legal range ≥ 1.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `atten_target`, input, SHIFT_W: requested attenuation in 6 dB steps (0 = unity); sampled every cycle.
- `in_valid`, input, 1: input sample present.
- `in_ready`, output, 1: block can accept a sample this cycle.
- `in_data`, input, WIDTH: signed input sample.
- `out_valid`, output, 1: output sample present.
- `out_ready`, input, 1: downstream accepts the output sample.
- `out_data`, output, WIDTH: signed attenuated sample.
- `atten_cur`, output, SHIFT_W: attenuation currently applied.
- `ramping`, output, 1: high when `atten_cur != atten_target`.

## Operation
- Reset values:
  - `out_valid = 0`, `out_data = 0`.
  - `atten_cur = MAX_ATT`: the block powers up muted and ramps in.
  - Internal sample counter = 0.
- Handshake:
  - `in_ready = !out_valid || out_ready`, combinational.
  - Accept = `in_valid && in_ready`.
  - On accept: `out_data <= in_data >>> atten_cur` (arithmetic shift, sign-extended, rounds toward −∞), using `atten_cur` as it was before this edge; `out_valid <= 1`.
  - On `out_ready && out_valid` with no accept: `out_valid <= 0`; `out_data` holds its last value.
  - `out_data` and `out_valid` are stable while `out_valid && !out_ready`.
- Ramp controller, states IDLE (`atten_cur == atten_target`) and STEP (not equal):
  - IDLE: the counter is held at 0.
  - STEP: the counter increments on each accept.
  - When an accept occurs with counter = `RAMP_SAMPLES-1`, `atten_cur` moves one step toward `atten_target` (+1 or −1) and the counter clears.
  - Stalled input means no steps: the ramp rate is tied to samples, not cycles.
  - If the target changes mid-ramp, the counter is not cleared, and the next step heads toward the new target.
  - If the target equals `atten_cur` mid-count, the state returns to IDLE and the counter clears.
- `ramping` is combinational from `atten_cur` and `atten_target`.
- Width rules:
  - Shift by `MAX_ATT` on a 16-bit sample yields only sign bits (0 or −1). No overflow is possible.
  - `atten_cur` never leaves the range 0..MAX_ATT.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 sample/cycle when `out_ready` is held high.
- Simultaneous accept and output drain in the same cycle: new data loads and `out_valid` stays 1.
- Sample ordering at a step: the sample that completes a step count uses the old attenuation; the next accepted sample uses the new one.
- Asserting `rst_n` low mid-stream: the held sample is discarded, and all state returns to reset values immediately (asynchronous).
- First release edge: no accept occurs before the first rising edge with `rst_n` high.

## Test plan
- Reset ramp-in:
  - Stimulus: `atten_target=0`, `RAMP_SAMPLES=4`, continuous `in_data=16'h4000`, `out_ready=1`.
  - Required: `atten_cur` goes 15→0 in 60 accepts. The first 4 outputs are `16'h0000`, the next 4 are `16'h0001`, and output 61 is `16'h4000`. `ramping` drops on the cycle `atten_cur` reaches 0.
- Negative sign extension:
  - Stimulus: `atten_cur=3` steady, `in_data=16'h8000`.
  - Required: `out_data=16'hF000`. With `in_data=16'hFFFF`, `out_data=16'hFFFF`.
- Backpressure:
  - Stimulus: `out_ready=0` for 5 cycles with `in_valid=1`.
  - Required: exactly one sample is accepted, `in_ready=0` after it, and `out_data` is stable. On release, there is no loss or duplication across a 100-sample sequence.
- Target reversal mid-ramp:
  - Stimulus: ramping 15→0 at `atten_cur=8`, counter=2; set target to 12.
  - Required: after 2 more accepts `atten_cur=9`, then +1 every 4 accepts until 12, then IDLE.
- Stalled input:
  - Stimulus: `in_valid=0` for 1000 cycles during a ramp.
  - Required: `atten_cur` and the counter are unchanged.
- Asynchronous reset:
  - Stimulus: pull `rst_n` low mid-edge-free interval while `out_valid=1`, `atten_cur=5`.
  - Required: `out_valid=0`, `out_data=0`, `atten_cur=15` immediately, without a clock edge.
